// File: rtl/usb_buffer_pkg.sv
// usb_buffer_pkg: shared sizing constants and types for the USB data buffer
package usb_buffer_pkg;
    localparam int BUF_DEPTH  = 64;
    localparam int BUF_DATA_W = 8;
    localparam int BUF_OCC_W  = $clog2(BUF_DEPTH) + 1;
    typedef logic [$clog2(BUF_DEPTH)-1:0] buf_ptr_t;
    typedef logic [BUF_OCC_W-1:0]         buf_occ_t;
endpackage

// File: rtl/usb_buffer_fifo_core.sv
// usb_buffer_fifo_core: circular byte store with pointers, fill count and clear
module usb_buffer_fifo_core
    import usb_buffer_pkg::*;
#(
    parameter int DATA_W = BUF_DATA_W,
    parameter int DEPTH  = BUF_DEPTH,
    parameter int OCC_W  = BUF_OCC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              pop_ok_o,
    output logic [OCC_W-1:0]  count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OCC_W-1:0]  cnt_q, cnt_d;
    logic              full, empty, push_ok;
    // A pop frees a slot this cycle, so a push while full is accepted only alongside a pop
    always_comb begin
        empty    = cnt_q == '0;
        full     = cnt_q == OCC_W'(DEPTH);
        pop_ok_o = pop_i & ~empty & ~clear_i;
        push_ok  = push_i & (~full | pop_ok_o) & ~clear_i;
        wptr_d   = clear_i ? '0 : wptr_q + PTR_W'(push_ok);
        rptr_d   = clear_i ? '0 : rptr_q + PTR_W'(pop_ok_o);
        cnt_d    = clear_i ? '0 : cnt_q + OCC_W'(push_ok) - OCC_W'(pop_ok_o);
    end
    // Storage is never reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end
    // Pointer and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/usb_data_buffer.sv
// usb_data_buffer: shared TX/RX byte FIFO with routed, registered pop outputs
module usb_data_buffer
    import usb_buffer_pkg::*;
#(
    parameter int DATA_W = BUF_DATA_W,
    parameter int DEPTH  = BUF_DEPTH,
    parameter int OCC_W  = BUF_OCC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              flush,
    input  logic              store_tx_data,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              store_rx_data,
    input  logic [DATA_W-1:0] RX_packet_data,
    input  logic              get_tx_data,
    input  logic              get_rx_data,
    output logic [OCC_W-1:0]  buff_occ,
    output logic [DATA_W-1:0] TX_packet_data,
    output logic [DATA_W-1:0] RX_data
);
    logic [DATA_W-1:0] rdata, tx_q, tx_d, rx_q, rx_d;
    logic              pop_ok;
    usb_buffer_fifo_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OCC_W(OCC_W)) u_core (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (clear | flush),
        .push_i   (store_tx_data | store_rx_data),
        .wdata_i  (store_tx_data ? tx_data : RX_packet_data),
        .pop_i    (get_tx_data | get_rx_data),
        .rdata_o  (rdata),
        .pop_ok_o (pop_ok),
        .count_o  (buff_occ)
    );
    // The TX pop request wins the head byte when both pops are asserted
    always_comb begin
        tx_d = (pop_ok & get_tx_data) ? rdata : tx_q;
        rx_d = (pop_ok & ~get_tx_data) ? rdata : rx_q;
    end
    // Output byte registers hold until a pop is routed to them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            tx_q <= tx_d;
            rx_q <= rx_d;
        end
    end
    assign TX_packet_data = tx_q;
    assign RX_data        = rx_q;
endmodule

// File: tb/tb_usb_data_buffer.sv
// tb_usb_data_buffer: randomized checks of usb_data_buffer against a queue model
module tb_usb_data_buffer;
    logic       clk = 0, rst = 1, clear = 0, flush = 0;
    logic       store_tx_data = 0, store_rx_data = 0, get_tx_data = 0, get_rx_data = 0;
    logic [7:0] tx_data = 0, RX_packet_data = 0;
    logic [6:0] buff_occ;
    logic [7:0] TX_packet_data, RX_data;
    int         passed = 0, total = 0;
    logic [7:0] q[$];
    logic [7:0] tx_m = 0, rx_m = 0;

    usb_data_buffer dut (
        .clk(clk), .rst(rst), .clear(clear), .flush(flush),
        .store_tx_data(store_tx_data), .tx_data(tx_data),
        .store_rx_data(store_rx_data), .RX_packet_data(RX_packet_data),
        .get_tx_data(get_tx_data), .get_rx_data(get_rx_data),
        .buff_occ(buff_occ), .TX_packet_data(TX_packet_data), .RX_data(RX_data)
    );

    always #5 clk = ~clk;

    // One clock with the given strobes; the model applies the buffer rules to a queue
    task automatic step(input logic c, f, st, input logic [7:0] td, input logic sr,
                        input logic [7:0] rd, input logic gt, gr);
        logic [7:0] b;
        bit po, pu;
        clear = c; flush = f; store_tx_data = st; tx_data = td;
        store_rx_data = sr; RX_packet_data = rd; get_tx_data = gt; get_rx_data = gr;
        @(posedge clk);
        if (c | f) q.delete();
        else begin
            po = (gt | gr) && q.size() != 0;
            pu = (st | sr) && (q.size() < 64 || po);
            if (po) begin
                b = q.pop_front();
                if (gt) tx_m = b; else rx_m = b;
            end
            if (pu) q.push_back(st ? td : rd);
        end
        #1;
        clear = 0; flush = 0; store_tx_data = 0; store_rx_data = 0;
        get_tx_data = 0; get_rx_data = 0;
    endtask

    task automatic test_reset();
        step(0, 0, 1, 8'h5A, 0, 8'h00, 0, 0);
        step(0, 0, 1, 8'hA5, 0, 8'h00, 0, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        #2 rst = 1;
        #1;
        total++; if (buff_occ !== 7'd0) $display("FAIL reset_async_occ got %0d exp 0", buff_occ); else passed++;
        total++; if (TX_packet_data !== 8'h00) $display("FAIL reset_async_tx got %h exp 00", TX_packet_data); else passed++;
        total++; if (RX_data !== 8'h00) $display("FAIL reset_async_rx got %h exp 00", RX_data); else passed++;
        repeat (2) @(posedge clk);
        #1;
        total++; if (buff_occ !== 7'd0) $display("FAIL reset_hold_occ got %0d exp 0", buff_occ); else passed++;
        total++; if (TX_packet_data !== 8'h00) $display("FAIL reset_hold_tx got %h exp 00", TX_packet_data); else passed++;
        total++; if (RX_data !== 8'h00) $display("FAIL reset_hold_rx got %h exp 00", RX_data); else passed++;
        rst = 0;
        q.delete(); tx_m = 0; rx_m = 0;
    endtask

    task automatic test_single_rx();
        step(0, 0, 0, 8'h00, 1, 8'hDE, 0, 0);
        total++; if (buff_occ !== 7'd1) $display("FAIL single_occ_push got %0d exp 1", buff_occ); else passed++;
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        total++; if (buff_occ !== 7'd0) $display("FAIL single_occ_pop got %0d exp 0", buff_occ); else passed++;
        total++; if (RX_data !== 8'hDE) $display("FAIL single_rx got %h exp de", RX_data); else passed++;
        total++; if (TX_packet_data !== 8'h00) $display("FAIL single_tx got %h exp 00", TX_packet_data); else passed++;
    endtask

    task automatic test_tx_seq();
        for (int i = 1; i <= 3; i++) step(0, 0, 1, 8'(i), 0, 8'hEE, 0, 0);
        total++; if (buff_occ !== 7'd3) $display("FAIL txseq_occ got %0d exp 3", buff_occ); else passed++;
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
            total++; if (TX_packet_data !== 8'(i)) $display("FAIL txseq_data got %h exp %h", TX_packet_data, 8'(i)); else passed++;
            total++; if (buff_occ !== 7'(3 - i)) $display("FAIL txseq_occ_pop got %0d exp %0d", buff_occ, 3 - i); else passed++;
        end
    endtask

    task automatic test_full();
        logic st;
        for (int i = 0; i < 64; i++) begin
            st = 1'($urandom_range(0, 1));
            step(0, 0, st, 8'(i), !st, 8'(i), 0, 0);
        end
        step(0, 0, 1, 8'hFF, 1, 8'hFF, 0, 0);
        total++; if (buff_occ !== 7'd64) $display("FAIL full_occ got %0d exp 64", buff_occ); else passed++;
        for (int i = 0; i < 64; i++) begin
            step(0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
            total++; if (RX_data !== 8'(i)) $display("FAIL full_order got %h exp %h", RX_data, 8'(i)); else passed++;
        end
        total++; if (buff_occ !== 7'd0) $display("FAIL full_drain_occ got %0d exp 0", buff_occ); else passed++;
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        total++; if (RX_data !== 8'd63) $display("FAIL empty_pop_hold got %h exp 3f", RX_data); else passed++;
    endtask

    task automatic test_clear_flush();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 1, 8'($urandom), 0, 0);
            step(0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
            step(k == 0, k == 1, 1, 8'h77, 1, 8'h88, 1, 1);
            total++; if (buff_occ !== 7'd0) $display("FAIL clr%0d_occ got %0d exp 0", k, buff_occ); else passed++;
            step(0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
            total++; if (RX_data !== rx_m) $display("FAIL clr%0d_rx_hold got %h exp %h", k, RX_data, rx_m); else passed++;
            total++; if (TX_packet_data !== tx_m) $display("FAIL clr%0d_tx_hold got %h exp %h", k, TX_packet_data, tx_m); else passed++;
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 60; i++) begin
            step(0, 0, 1, 8'($urandom), 0, 8'h00, 0, 0);
            step(0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        end
        for (int i = 0; i < 10; i++) step(0, 0, 0, 8'h00, 1, 8'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 8'h00, 1, 8'($urandom), 1, 0);
            total++; if (buff_occ !== 7'd10) $display("FAIL wrap_occ got %0d exp 10", buff_occ); else passed++;
            total++; if (TX_packet_data !== tx_m) $display("FAIL wrap_tx got %h exp %h", TX_packet_data, tx_m); else passed++;
        end
    endtask

    task automatic test_random();
        int push_pct;
        for (int i = 0; i < 800; i++) begin
            push_pct = ((i / 100) % 2 == 0) ? 85 : 20;
            step($urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 99) < push_pct / 2, 8'($urandom),
                 $urandom_range(0, 99) < push_pct, 8'($urandom),
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30);
            total++; if (buff_occ !== 7'(q.size())) $display("FAIL rand_occ cyc %0d got %0d exp %0d", i, buff_occ, q.size()); else passed++;
            total++; if (TX_packet_data !== tx_m) $display("FAIL rand_tx cyc %0d got %h exp %h", i, TX_packet_data, tx_m); else passed++;
            total++; if (RX_data !== rx_m) $display("FAIL rand_rx cyc %0d got %h exp %h", i, RX_data, rx_m); else passed++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        test_reset();
        test_single_rx();
        test_tx_seq();
        test_full();
        test_clear_flush();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/usb_data_buffer.md
Name: usb_data_buffer

Overview:
- Single 64-byte data FIFO shared by the USB endpoint's TX and RX data paths.
- Bytes arrive from the host-side interface (tx_data) or the USB receiver (RX_packet_data).
- Bytes leave toward the USB transmitter (TX_packet_data) or the host-side interface (RX_data).
- buff_occ reports the current fill level to the protocol controller and the host interface.

Parameters:
- DATA_W, 8, byte width of every storage entry and data port.
- DEPTH, 64, number of FIFO entries; must be a power of two.
- OCC_W, 7, occupancy width, equal to clog2(DEPTH)+1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous empty request from the host interface.
- flush  in  1  synchronous empty request from the protocol controller.
- store_tx_data  in  1  push tx_data this cycle.
- tx_data  in  8  byte from the host interface.
- store_rx_data  in  1  push RX_packet_data this cycle.
- RX_packet_data  in  8  byte from the USB receiver.
- get_tx_data  in  1  pop the head byte into TX_packet_data.
- get_rx_data  in  1  pop the head byte into RX_data.
- buff_occ  out  7  number of valid bytes, 0..64.
- TX_packet_data  out  8  registered, last byte popped via get_tx_data.
- RX_data  out  8  registered, last byte popped via get_rx_data.

Behaviour:
- Reset: while rst=1, asynchronously force the following to 0:
  - write pointer, read pointer and count, so buff_occ=0;
  - TX_packet_data and RX_data.
  - Storage array contents need not be reset.
- Storage: DEPTH x DATA_W memory. Write and read pointers are log2(DEPTH) bits wide and wrap modulo DEPTH (63 -> 0). The count register drives buff_occ directly.
- Priority each cycle: rst > (clear | flush) > normal operation.
- clear or flush = 1:
  - next edge sets pointers and count to 0;
  - any simultaneous push or pop is ignored;
  - TX_packet_data and RX_data hold their values.
- Push: push = store_tx_data | store_rx_data.
  - Write data is tx_data when store_tx_data=1, otherwise RX_packet_data. If both strobes are high, store_tx_data wins and exactly one byte is written.
  - The byte goes to mem[wptr]; wptr increments.
  - Takes effect at the edge where the strobe is sampled high. The byte is poppable from the next cycle on.
- Pop: pop = get_tx_data | get_rx_data.
  - mem[rptr] is loaded into TX_packet_data when get_tx_data=1, else into RX_data. If both are high, only TX_packet_data loads. rptr increments.
  - Output valid immediately after the sampling edge (1-cycle latency).
  - The output register holds until the next pop routed to it.
- Full (count=64): push is dropped; pointers, count and memory are unchanged.
- Empty (count=0): pop is dropped; output registers hold and rptr is unchanged.
  - A simultaneous push and pop when empty performs only the push (no write-through bypass).
- Push and pop in the same cycle, not empty and not full: both happen and count is unchanged.
- Push and pop in the same cycle when full: both happen. The pop reads the old head and the push writes into the freed slot.
- Count update: +1 on push only, -1 on pop only, unchanged on neither or both. It never leaves 0..64.
- Strobes are level-sampled: each high cycle is one transfer.

Decomposition:
- Shared package usb_buffer_pkg:
  - constants BUF_DEPTH=64, BUF_DATA_W=8, BUF_OCC_W=7;
  - pointer typedef buf_ptr_t (6 bits) and occupancy typedef buf_occ_t (7 bits).
- One natural sub-module, usb_buffer_fifo_core. It holds the memory, pointers, count, full/empty and the push/pop/clear logic.
- Top level: TX/RX input muxing and routing of the popped byte to the two output registers.

Test Plan:
- Assert rst for 2 cycles mid-idle -> buff_occ=0, RX_data=0x00, TX_packet_data=0x00 while rst is high.
- store_rx_data with RX_packet_data=0xDE for 1 cycle, then get_rx_data for 1 cycle:
  - buff_occ reads 1 after the push, 0 after the pop;
  - RX_data=0xDE, TX_packet_data=0x00.
- Push 0x01,0x02,0x03 via store_tx_data, then get_tx_data x3 -> TX_packet_data sequence 0x01,0x02,0x03; buff_occ 3 -> 0.
- Push 64 bytes (i = 0..63), then one extra push of 0xFF:
  - buff_occ=64 and the extra push is dropped;
  - 64 get_rx_data pops return 0..63 in order.
- With 5 bytes stored, pulse clear for 1 cycle:
  - buff_occ=0 next cycle and a pop leaves RX_data unchanged.
  - Repeat with flush for the same result.
- With 10 bytes stored, hold store_rx_data and get_tx_data together for 20 cycles -> buff_occ stays 10, FIFO order preserved across pointer wrap.
